// File: rtl/kernel_ctrl_s_axi_regs.sv
// AXI4-Lite control register file for the kernel: start/done/idle, interrupts and 8 pointers.
// Define CTRL_AUTO_RESTART_EN to make CTRL bit7 (auto_restart) writable.
module kernel_ctrl_s_axi_regs #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            s_axi_control_awvalid,
    output logic                            s_axi_control_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                            s_axi_control_wvalid,
    output logic                            s_axi_control_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                            s_axi_control_bvalid,
    input  logic                            s_axi_control_bready,
    output logic [1:0]                      s_axi_control_bresp,
    input  logic                            s_axi_control_arvalid,
    output logic                            s_axi_control_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                            s_axi_control_rvalid,
    input  logic                            s_axi_control_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                      s_axi_control_rresp,
    output logic                            interrupt,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_idle,
    output logic [63:0]                     axi00_ptr0,
    output logic [63:0]                     axi00_ptr1,
    output logic [63:0]                     axi00_ptr2,
    output logic [63:0]                     axi00_ptr3,
    output logic [63:0]                     axi00_ptr4,
    output logic [63:0]                     axi00_ptr5,
    output logic [63:0]                     axi00_ptr6,
    output logic [63:0]                     axi00_ptr7
);

    localparam logic [1:0] WRIDLE = 2'd0;
    localparam logic [1:0] WRDATA = 2'd1;
    localparam logic [1:0] WRRESP = 2'd2;
    localparam logic       RDIDLE = 1'b0;
    localparam logic       RDDATA = 1'b1;

    logic [1:0]  wstate;
    logic        rstate;
    logic [4:0]  waddr;
    logic [4:0]  raddr;
    logic [4:0]  wofs;
    logic [4:0]  rofs;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        ap_start_q, done_q, auto_restart_q, gie_q, ier_q, isr_q, interrupt_q;
    logic [63:0] ptr_q [8];
    logic        w_hs, ar_hs, wr_ctrl, wr_gie, wr_ier, wr_isr;
    logic        unused_addr;

    assign unused_addr = ^{s_axi_control_awaddr[C_S_AXI_ADDR_WIDTH-1:7], s_axi_control_awaddr[1:0],
                           s_axi_control_araddr[C_S_AXI_ADDR_WIDTH-1:7], s_axi_control_araddr[1:0]};

    assign s_axi_control_awready = (wstate == WRIDLE);
    assign s_axi_control_wready  = (wstate == WRDATA);
    assign s_axi_control_bvalid  = (wstate == WRRESP);
    assign s_axi_control_bresp   = 2'b00;
    assign s_axi_control_arready = (rstate == RDIDLE);
    assign s_axi_control_rvalid  = (rstate == RDDATA);
    assign s_axi_control_rresp   = 2'b00;
    assign s_axi_control_rdata   = rdata_q;
    assign interrupt             = interrupt_q;
    assign ap_start              = ap_start_q;

    assign w_hs    = (wstate == WRDATA) && s_axi_control_wvalid;
    assign ar_hs   = (rstate == RDIDLE) && s_axi_control_arvalid;
    assign raddr   = s_axi_control_araddr[6:2];
    // Pointer word offset; bit4 set means outside 0x10..0x4C (also covers 0x00..0x0C).
    assign wofs    = waddr - 5'd4;
    assign rofs    = raddr - 5'd4;
    assign wr_ctrl = w_hs && (waddr == 5'd0) && s_axi_control_wstrb[0];
    assign wr_gie  = w_hs && (waddr == 5'd1) && s_axi_control_wstrb[0];
    assign wr_ier  = w_hs && (waddr == 5'd2) && s_axi_control_wstrb[0];
    assign wr_isr  = w_hs && (waddr == 5'd3) && s_axi_control_wstrb[0];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wstate <= WRIDLE;
            waddr  <= '0;
        end else begin
            case (wstate)
                WRIDLE: if (s_axi_control_awvalid) begin
                    waddr  <= s_axi_control_awaddr[6:2];
                    wstate <= WRDATA;
                end
                WRDATA:  if (s_axi_control_wvalid) wstate <= WRRESP;
                WRRESP:  if (s_axi_control_bready) wstate <= WRIDLE;
                default: wstate <= WRIDLE;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (raddr)
            5'd0: rdata_d = {24'b0, auto_restart_q, 4'b0, ap_idle, done_q, ap_start_q};
            5'd1: rdata_d = {31'b0, gie_q};
            5'd2: rdata_d = {31'b0, ier_q};
            5'd3: rdata_d = {31'b0, isr_q};
            default: begin
                if (!rofs[4]) begin
                    rdata_d = rofs[0] ? ptr_q[rofs[3:1]][63:32] : ptr_q[rofs[3:1]][31:0];
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rstate  <= RDIDLE;
            rdata_q <= '0;
        end else begin
            case (rstate)
                RDIDLE: if (s_axi_control_arvalid) begin
                    rdata_q <= rdata_d;
                    rstate  <= RDDATA;
                end
                RDDATA:  if (s_axi_control_rready) rstate <= RDIDLE;
                default: rstate <= RDIDLE;
            endcase
        end
    end

`ifdef CTRL_AUTO_RESTART_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            auto_restart_q <= 1'b0;
        end else if (wr_ctrl) begin
            auto_restart_q <= s_axi_control_wdata[7];
        end
    end
`else
    assign auto_restart_q = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start_q  <= 1'b0;
            done_q      <= 1'b0;
            gie_q       <= 1'b0;
            ier_q       <= 1'b0;
            isr_q       <= 1'b0;
            interrupt_q <= 1'b0;
        end else begin
            // Host set beats the completion pulse so a back-to-back start is never dropped.
            if (wr_ctrl && s_axi_control_wdata[0]) ap_start_q <= 1'b1;
            else if (ap_done)                      ap_start_q <= auto_restart_q;
            if (ap_done)                           done_q <= 1'b1;
            else if (ar_hs && raddr == 5'd0)       done_q <= 1'b0;
            if (wr_gie) gie_q <= s_axi_control_wdata[0];
            if (wr_ier) ier_q <= s_axi_control_wdata[0];
            if (ap_done && ier_q)                       isr_q <= 1'b1;
            else if (wr_isr && s_axi_control_wdata[0])  isr_q <= ~isr_q;
            interrupt_q <= gie_q & isr_q;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < 8; i++) ptr_q[i] <= '0;
        end else if (w_hs && !wofs[4]) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_control_wstrb[b]) begin
                    if (wofs[0]) ptr_q[wofs[3:1]][32+8*b +: 8] <= s_axi_control_wdata[8*b +: 8];
                    else         ptr_q[wofs[3:1]][8*b +: 8]    <= s_axi_control_wdata[8*b +: 8];
                end
            end
        end
    end

    assign axi00_ptr0 = ptr_q[0];
    assign axi00_ptr1 = ptr_q[1];
    assign axi00_ptr2 = ptr_q[2];
    assign axi00_ptr3 = ptr_q[3];
    assign axi00_ptr4 = ptr_q[4];
    assign axi00_ptr5 = ptr_q[5];
    assign axi00_ptr6 = ptr_q[6];
    assign axi00_ptr7 = ptr_q[7];

endmodule

// File: tb/tb_kernel_ctrl_s_axi_regs.sv
// Directed bench for kernel_ctrl_s_axi_regs: drives and samples on the falling clock edge.
module tb_kernel_ctrl_s_axi_regs;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, interrupt, ap_start;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        ap_done = 1'b0, ap_idle = 1'b1;
    logic [63:0] ptr0, ptr1, ptr2, ptr3, ptr4, ptr5, ptr6, ptr7;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 ap_clk = ~ap_clk;

    kernel_ctrl_s_axi_regs dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
        .s_axi_control_awaddr(awaddr),
        .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
        .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
        .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
        .s_axi_control_bresp(bresp),
        .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
        .s_axi_control_araddr(araddr),
        .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
        .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
        .interrupt(interrupt), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .axi00_ptr0(ptr0), .axi00_ptr1(ptr1), .axi00_ptr2(ptr2), .axi00_ptr3(ptr3),
        .axi00_ptr4(ptr4), .axi00_ptr5(ptr5), .axi00_ptr6(ptr6), .axi00_ptr7(ptr7)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb = 4'hF, input bit done_on_w = 1'b0,
                             input int stall = 0);
        awaddr  = addr;
        awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) @(negedge ap_clk);
        check("aw_timeout", awready, 1);
        @(negedge ap_clk);
        awvalid = 1'b0;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        for (int n = 0; n < 50 && !wready; n++) @(negedge ap_clk);
        check("w_timeout", wready, 1);
        if (done_on_w) ap_done = 1'b1;
        @(negedge ap_clk);
        ap_done = 1'b0;
        wvalid  = 1'b0;
        for (int n = 0; n < 50 && !bvalid; n++) @(negedge ap_clk);
        check("b_timeout", bvalid, 1);
        check("bresp", bresp, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge ap_clk);
            check("b_stall_bvalid", bvalid, 1);
            check("b_stall_awready", awready, 0);
        end
        bready = 1'b1;
        @(negedge ap_clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp, input string tag,
                            input bit done_on_ar = 1'b0, input int stall = 0);
        araddr  = addr;
        arvalid = 1'b1;
        for (int n = 0; n < 50 && !arready; n++) @(negedge ap_clk);
        check("ar_timeout", arready, 1);
        if (done_on_ar) ap_done = 1'b1;
        @(negedge ap_clk);
        ap_done = 1'b0;
        arvalid = 1'b0;
        for (int n = 0; n < 50 && !rvalid; n++) @(negedge ap_clk);
        check("r_timeout", rvalid, 1);
        for (int i = 0; i < stall; i++) begin
            check("r_stall_rdata", rdata, exp);
            check("r_stall_arready", arready, 0);
            @(negedge ap_clk);
            check("r_stall_rvalid", rvalid, 1);
        end
        check(tag, rdata, exp);
        check("rresp", rresp, 0);
        rready = 1'b1;
        @(negedge ap_clk);
        rready = 1'b0;
    endtask

    task automatic pulse_done();
        ap_done = 1'b1;
        @(negedge ap_clk);
        ap_done = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_ap_start", ap_start, 0);
        check("rst_interrupt", interrupt, 0);
        check("rst_ptr0", ptr0, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Pointer 0 assembled from two halves.
        axi_write(12'h010, 32'h1000_0000);
        axi_write(12'h014, 32'h0000_0004);
        check("ptr0", ptr0, 64'h4_1000_0000);
        axi_read(12'h010, 32'h1000_0000, "rd_ptr0_lo");
        axi_read(12'h014, 32'h0000_0004, "rd_ptr0_hi");

        // Byte strobes on pointer 7 low word.
        axi_write(12'h048, 32'h1122_3344);
        axi_write(12'h048, 32'hAABB_CCDD, 4'b0011);
        check("ptr7_strb", ptr7, 64'h0000_0000_1122_CCDD);
        axi_read(12'h048, 32'h1122_CCDD, "rd_ptr7_lo");
        axi_read(12'h04C, 32'h0, "rd_ptr7_hi");

        // Unmapped address: accepted, ignored, reads 0.
        axi_write(12'h050, 32'hFFFF_FFFF);
        axi_read(12'h050, 32'h0, "rd_unmapped");
        check("ptr0_after_unmapped", ptr0, 64'h4_1000_0000);

        // Start, pointer write while running, done.
        ap_idle = 1'b0;
        axi_write(12'h000, 32'h1);
        check("ap_start_set", ap_start, 1);
        axi_write(12'h018, 32'hDEAD_0000);
        check("ptr1_while_run", ptr1, 64'h0000_0000_DEAD_0000);
        check("ptr0_hold", ptr0, 64'h4_1000_0000);
        pulse_done();
        ap_idle = 1'b1;
        check("ap_start_clr", ap_start, 0);
        axi_read(12'h000, 32'h6, "ctrl_done");
        axi_read(12'h000, 32'h4, "ctrl_cor");

        // Write-set and done in the same cycle; CTRL bit0=0 write does nothing.
        axi_write(12'h000, 32'h1, 4'hF, 1'b1);
        check("ap_start_set_wins", ap_start, 1);
        axi_write(12'h000, 32'h0);
        check("ap_start_wr0", ap_start, 1);
        pulse_done();
        check("ap_start_clr2", ap_start, 0);
        axi_read(12'h000, 32'h6, "ctrl_done2");

        axi_write(12'h000, 32'h80);
`ifdef CTRL_AUTO_RESTART_EN
        axi_read(12'h000, 32'h84, "ctrl_bit7");
`else
        axi_read(12'h000, 32'h04, "ctrl_bit7");
`endif
        axi_write(12'h000, 32'h0);

        // Interrupt path.
        axi_write(12'h004, 32'h1);
        axi_write(12'h008, 32'h1);
        pulse_done();
        @(negedge ap_clk);
        check("irq_set", interrupt, 1);
        axi_read(12'h00C, 32'h1, "isr_set");
        axi_write(12'h00C, 32'h1);
        check("irq_clr", interrupt, 0);
        axi_read(12'h00C, 32'h0, "isr_toggled");
        axi_write(12'h00C, 32'h1, 4'hF, 1'b1);
        axi_read(12'h00C, 32'h1, "isr_set_wins");
        check("irq_set_wins", interrupt, 1);
        axi_write(12'h00C, 32'h1);
        axi_read(12'h000, 32'h6, "ctrl_done3");

        // ap_done coincident with a CTRL read: read sees old flag, flag survives.
        axi_read(12'h000, 32'h4, "ctrl_race_old", 1'b1);
        axi_read(12'h000, 32'h6, "ctrl_race_kept");

        // Back-pressure on B and R channels.
        axi_write(12'h020, 32'h1234_5678, 4'hF, 1'b0, 5);
        axi_read(12'h020, 32'h1234_5678, "rd_ptr2_stall", 1'b0, 5);

        // Reset in WRDATA.
        axi_write(12'h000, 32'h1);
        check("ap_start_pre_rst", ap_start, 1);
        awaddr  = 12'h010;
        awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) @(negedge ap_clk);
        @(negedge ap_clk);
        awvalid = 1'b0;
        check("in_wrdata", wready, 1);
        ap_rst_n = 1'b0;
        #1;
        check("arst_awready", awready, 1);
        check("arst_wready", wready, 0);
        check("arst_bvalid", bvalid, 0);
        check("arst_arready", arready, 1);
        check("arst_ap_start", ap_start, 0);
        check("arst_interrupt", interrupt, 0);
        check("arst_ptr0", ptr0, 0);
        check("arst_ptr2", ptr2, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        bready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            check("post_rst_bvalid", bvalid, 0);
        end
        bready = 1'b0;
        axi_read(12'h000, 32'h4, "ctrl_post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1);
    end

endmodule
